// File: rtl/video_render_zx.sv
// ZX-mode pixel renderer: serialises each fetched 64-bit word into 16 pixels
// (one per cend), applies ink/paper/bright/flash attribute colouring and
// substitutes the border colour outside the active window.
// Optional feature macro: VIDEO_ZX_FLASH_EN (attribute flash; off by default).
module video_render_zx #(
  parameter int FLASH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cend,
  input  logic        fetch_sync,
  input  logic [63:0] pic_bits,
  input  logic        int_start,
  input  logic        hpix,
  input  logic        vpix,
  input  logic [2:0]  border,
  output logic [3:0]  color
);

  logic [15:0] shift_reg;
  logic [7:0]  attr0_reg;
  logic [7:0]  attr1_reg;
  logic [3:0]  pix_ctr_reg;
  logic        flash_phase;

  logic [7:0]  attr_sel;
  logic        pix_bit;
  logic [3:0]  color_next;

`ifdef VIDEO_ZX_FLASH_EN
  logic [FLASH_LOG2:0] flash_ctr_reg;

  // Frame counter: counts frame-start pulses regardless of the pixel strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_ctr_reg <= '0;
    end else if (int_start) begin
      flash_ctr_reg <= flash_ctr_reg + {{FLASH_LOG2{1'b0}}, 1'b1};
    end
  end

  assign flash_phase = flash_ctr_reg[FLASH_LOG2];

  // Upper half of the fetch word carries nothing for ZX mode
  logic unused_bits;
  assign unused_bits = ^pic_bits[63:32];
`else
  // Without flash support the phase is pinned low, so attr[7] has no effect
  assign flash_phase = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{pic_bits[63:32], int_start} ^ (FLASH_LOG2 < 0);
`endif

  // Pixel colour from the pre-edge shift/attribute state and current window
  always_comb begin
    attr_sel   = pix_ctr_reg[3] ? attr1_reg : attr0_reg;
    pix_bit    = shift_reg[15] ^ (attr_sel[7] & flash_phase);
    color_next = {1'b0, border};
    if (hpix && vpix) begin
      color_next = pix_bit ? {attr_sel[6], attr_sel[2:0]}
                           : {attr_sel[6], attr_sel[5:3]};
    end
  end

  // Emit one pixel per cend; a load replaces the shift so the stream is gapless
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color       <= 4'd0;
      shift_reg   <= 16'd0;
      attr0_reg   <= 8'd0;
      attr1_reg   <= 8'd0;
      pix_ctr_reg <= 4'd0;
    end else if (cend) begin
      color <= color_next;
      if (fetch_sync) begin
        shift_reg   <= {pic_bits[7:0], pic_bits[23:16]};
        attr0_reg   <= pic_bits[15:8];
        attr1_reg   <= pic_bits[31:24];
        pix_ctr_reg <= 4'd0;
      end else begin
        shift_reg   <= {shift_reg[14:0], 1'b0};
        pix_ctr_reg <= pix_ctr_reg + 4'd1;
      end
    end
  end

endmodule
